// File: rtl/data_mem_unit_pkg.sv
// Shared definitions for the data memory unit: FSM state encoding, access sizes
// and the alignment rule used when a request is accepted.
package data_mem_unit_pkg;

  localparam int WORD_W = 32;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RD   = 2'd1;
  localparam state_t ST_WR   = 2'd2;
  localparam state_t ST_RESP = 2'd3;

  typedef logic [1:0] size_t;
  localparam size_t SZ_BYTE = 2'b00;
  localparam size_t SZ_HALF = 2'b01;
  localparam size_t SZ_WORD = 2'b10;

  // Size 2'b11 falls into the default branch and is treated as a word access.
  function automatic logic is_misaligned(input size_t size, input logic [1:0] lsb);
    logic mis;
    case (size)
      SZ_BYTE: mis = 1'b0;
      SZ_HALF: mis = lsb[0];
      default: mis = (lsb != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/data_mem_unit_lane_mux.sv
// Little-endian byte/halfword lane logic: load extraction with sign/zero
// extension, and merging of right-justified store data into a read word.
module dmem_lane_mux
  import data_mem_unit_pkg::*;
(
  input  logic [WORD_W-1:0] word,
  input  size_t             size,
  input  logic              sign_ext,
  input  logic [1:0]        lane,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] load_data,
  output logic [WORD_W-1:0] merged
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Load path: select the addressed lane, then extend to a full word.
  always_comb begin
    byte_s    = 8'd0;
    half_s    = 16'd0;
    load_data = word;
    case (lane)
      2'd0:    byte_s = word[7:0];
      2'd1:    byte_s = word[15:8];
      2'd2:    byte_s = word[23:16];
      default: byte_s = word[31:24];
    endcase
    if (lane[1]) begin
      half_s = word[31:16];
    end else begin
      half_s = word[15:0];
    end
    case (size)
      SZ_BYTE: load_data = {{24{sign_ext & byte_s[7]}}, byte_s};
      SZ_HALF: load_data = {{16{sign_ext & half_s[15]}}, half_s};
      default: load_data = word;
    endcase
  end

  // Store path: replace only the lane(s) being written.
  always_comb begin
    merged = wdata;
    case (size)
      SZ_BYTE: begin
        case (lane)
          2'd0:    merged = {word[31:8], wdata[7:0]};
          2'd1:    merged = {word[31:16], wdata[7:0], word[7:0]};
          2'd2:    merged = {word[31:24], wdata[7:0], word[15:0]};
          default: merged = {wdata[7:0], word[23:0]};
        endcase
      end
      SZ_HALF: begin
        if (lane[1]) begin
          merged = {wdata[15:0], word[15:0]};
        end else begin
          merged = {word[31:16], wdata[15:0]};
        end
      end
      default: merged = wdata;
    endcase
  end

endmodule

// File: rtl/data_mem_unit.sv
// Single-port data memory with byte/half/word loads and read-modify-write stores,
// sequenced by a four-state FSM; misaligned requests complete without touching state.
module data_mem_unit
  import data_mem_unit_pkg::*;
#(
  parameter int DEPTH     = 256,
  parameter bit INIT_ZERO = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              sign_ext,
  input  logic [31:0]       addr,
  input  logic [WORD_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic [WORD_W-1:0] rdata,
  output logic              misalign
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [WORD_W-1:0] INIT_WORD = INIT_ZERO ? 32'h0000_0000 : 32'hxxxx_xxxx;

  logic [WORD_W-1:0] mem_r [DEPTH] = '{default: INIT_WORD};

  state_t            state_r, state_s;
  logic              we_r, sext_r;
  size_t             size_r;
  logic [IDX_W+1:0]  addr_r;
  logic [WORD_W-1:0] wdata_r, word_r, rdata_r;
  logic              done_r, misalign_r, busy_r;
  logic [IDX_W-1:0]  idx_s;
  logic [WORD_W-1:0] rd_word_s, mux_word_s, load_data_s, merged_s;
  logic              req_mis_s;
  logic              unused_addr_s;

  assign unused_addr_s = ^addr[31:IDX_W+2];
  assign idx_s         = addr_r[IDX_W+1:2];
  assign rd_word_s     = mem_r[idx_s];
  assign req_mis_s     = is_misaligned(size, addr[1:0]);
  // RD extracts straight from the array; WR merges into the word captured in RD.
  assign mux_word_s    = (state_r == ST_WR) ? word_r : rd_word_s;

  dmem_lane_mux u_lane_mux (
    .word      (mux_word_s),
    .size      (size_r),
    .sign_ext  (sext_r),
    .lane      (addr_r[1:0]),
    .wdata     (wdata_r),
    .load_data (load_data_s),
    .merged    (merged_s)
  );

  // Next-state selection.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (req) begin
          state_s = req_mis_s ? ST_RESP : ST_RD;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RD:   state_s = we_r ? ST_WR : ST_RESP;
      ST_WR:   state_s = ST_RESP;
      ST_RESP: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // FSM, request latch and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      we_r       <= 1'b0;
      size_r     <= SZ_BYTE;
      sext_r     <= 1'b0;
      addr_r     <= '0;
      wdata_r    <= 32'd0;
      word_r     <= 32'd0;
      rdata_r    <= 32'd0;
      done_r     <= 1'b0;
      misalign_r <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      state_r <= state_s;
      busy_r  <= (state_s != ST_IDLE);
      done_r  <= (state_s == ST_RESP);
      if (state_r == ST_IDLE && req) begin
        we_r    <= we;
        size_r  <= size;
        sext_r  <= sign_ext;
        addr_r  <= addr[IDX_W+1:0];
        wdata_r <= wdata;
      end
      // Only the direct IDLE->RESP path is a rejected access.
      if (state_s == ST_RESP) begin
        misalign_r <= (state_r == ST_IDLE);
      end
      if (state_r == ST_RD) begin
        word_r <= rd_word_s;
        if (!we_r) begin
          rdata_r <= load_data_s;
        end
      end
    end
  end

  // Array write; a reset on the WR edge drops the write, contents are never cleared.
  always_ff @(posedge clk) begin
    if (rst_n && state_r == ST_WR) begin
      mem_r[idx_s] <= merged_s;
    end
  end

  assign busy     = busy_r;
  assign done     = done_r;
  assign rdata    = rdata_r;
  assign misalign = misalign_r;

endmodule

// File: tb/tb_data_mem_unit.sv
// Randomised scoreboard bench for data_mem_unit against a byte-array reference model.
module tb_data_mem_unit;

  typedef struct {
    logic [31:0] rdata;
    logic        misalign;
    int          lat;
    int          sample_cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [1:0]  size = 2'b00;
  logic        sign_ext = 1'b0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic        busy, done, misalign;
  logic [31:0] rdata;

  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  exp_t        sb_q[$];
  logic [7:0]  mem_b [1024];
  logic [31:0] last_rdata = 32'd0;

  data_mem_unit #(.DEPTH(256), .INIT_ZERO(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .size(size), .sign_ext(sign_ext),
    .addr(addr), .wdata(wdata), .busy(busy), .done(done), .rdata(rdata), .misalign(misalign)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done !== 1'b0) begin
      exp_t e;
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_done: got done=%b, expected no completion (cycle %0d)", done, cyc);
      end else begin
        e = sb_q.pop_front();
        check("rdata", rdata, e.rdata);
        check("misalign", {31'd0, misalign}, {31'd0, e.misalign});
        check("latency", 32'(cyc - e.sample_cyc + 1), 32'(e.lat));
      end
    end
  end

  task automatic wait_idle();
    int k = 0;
    @(negedge clk);
    while (busy !== 1'b0 && k < 10) begin
      @(negedge clk);
      k++;
    end
    if (busy !== 1'b0) begin
      n_cmp++;
      n_err++;
      $display("FAIL busy_timeout: got busy=%b after %0d cycles, expected 0", busy, k);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
    check({tag, "_misalign"}, {31'd0, misalign}, 32'd0);
    check({tag, "_rdata"}, rdata, 32'd0);
  endtask

  // Issue one access from a negedge; the model decides the outcome from byte-level rules.
  task automatic access(input logic w, input logic [1:0] sz, input logic sx,
                        input logic [31:0] a, input logic [31:0] d, input int hold,
                        input bit use_lit, input logic [31:0] lit);
    exp_t        e;
    int          n;
    int          b;
    logic        mis;
    logic [63:0] v;
    n   = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    mis = (n == 2 && a[0]) || (n == 4 && a[1:0] != 2'b00);
    b   = int'(a[9:0]);
    if (mis) begin
      e.lat = 1;
    end else if (w) begin
      for (int i = 0; i < n; i++) mem_b[b + i] = d[8*i +: 8];
      e.lat = 3;
    end else begin
      v = 64'd0;
      for (int i = 0; i < n; i++) v = v | (64'(mem_b[b + i]) << (8 * i));
      if (sx && n < 4 && v[8*n-1]) v = v | (~64'd0 << (8 * n));
      last_rdata = v[31:0];
      e.lat = 2;
    end
    e.rdata      = use_lit ? lit : last_rdata;
    e.misalign   = mis;
    e.sample_cyc = cyc + 1;
    sb_q.push_back(e);
    req = 1'b1; we = w; size = sz; sign_ext = sx; addr = a; wdata = d;
    for (int h = 0; h <= hold; h++) begin
      @(negedge clk);
      we = 1'($urandom); size = 2'($urandom); sign_ext = 1'($urandom);
      addr = $urandom; wdata = $urandom;
      req = (h < hold) ? 1'b1 : 1'b0;
    end
    wait_idle();
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem_b[i] = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    access(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 0, 1'b0, 32'd0);
    access(1'b0, 2'b10, 1'b0, 32'h10, 32'd0, 0, 1'b1, 32'hDEADBEEF);
    access(1'b0, 2'b00, 1'b1, 32'h13, 32'd0, 0, 1'b1, 32'hFFFFFFDE);
    access(1'b0, 2'b00, 1'b0, 32'h13, 32'd0, 0, 1'b1, 32'h000000DE);
    access(1'b0, 2'b01, 1'b1, 32'h10, 32'd0, 0, 1'b1, 32'hFFFFBEEF);
    access(1'b1, 2'b00, 1'b0, 32'h11, 32'h00000055, 0, 1'b1, 32'hFFFFBEEF);
    access(1'b0, 2'b10, 1'b0, 32'h10, 32'd0, 0, 1'b1, 32'hDEAD55EF);
    access(1'b0, 2'b10, 1'b0, 32'h12, 32'd0, 0, 1'b1, 32'hDEAD55EF);
    access(1'b1, 2'b01, 1'b0, 32'h21, 32'h0000ABCD, 0, 1'b1, 32'hDEAD55EF);
    access(1'b0, 2'b10, 1'b0, 32'h20, 32'd0, 0, 1'b1, 32'h00000000);
    access(1'b0, 2'b11, 1'b0, 32'h10, 32'd0, 0, 1'b1, 32'hDEAD55EF);

    // Second req while in RD must be dropped: exactly one completion.
    access(1'b0, 2'b01, 1'b0, 32'h12, 32'd0, 1, 1'b1, 32'h0000DEAD);

    // Reset on the WR edge of a store to 0x30 suppresses the write.
    access(1'b1, 2'b10, 1'b0, 32'h30, 32'h12345678, 0, 1'b0, 32'd0);
    req = 1'b1; we = 1'b1; size = 2'b10; addr = 32'h30; wdata = 32'hCAFEF00D;
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    rst_n = 1'b0; req = 1'b1; we = 1'b0; addr = 32'h10;
    @(negedge clk);
    check_reset_outputs("wr_reset");
    @(negedge clk);
    check_reset_outputs("req_in_reset");
    last_rdata = 32'd0;
    rst_n = 1'b1; req = 1'b0;
    @(negedge clk);
    check({"post_reset_busy"}, {31'd0, busy}, 32'd0);
    access(1'b1, 2'b00, 1'b0, 32'h31, 32'h000000AA, 0, 1'b1, 32'h00000000);
    access(1'b0, 2'b10, 1'b0, 32'h30, 32'd0, 0, 1'b1, 32'h1234AA78);

    for (int t = 0; t < 300; t++) begin
      logic [31:0] ra;
      ra = ($urandom & 32'hFFFF_FC00) | 32'($urandom_range(0, 63));
      repeat ($urandom_range(0, 2)) @(negedge clk);
      access(1'($urandom), 2'($urandom), 1'($urandom), ra, $urandom, 0, 1'b0, 32'd0);
    end

    repeat (5) @(negedge clk);
    check("outstanding_completions", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/data_mem_unit.md
DATA_MEM_UNIT -- requirements
Module: data_mem_unit

Interface
REQ-001 Parameter DEPTH, default 256, number of 32-bit words in the data array (power of two).
REQ-002 Parameter INIT_ZERO, default 1, when 1 the array simulation-initialises to zero; it is never cleared by reset.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset; synchronous, active-low.
REQ-005 req  input  1  start of access; sampled only in IDLE.
REQ-006 we  input  1  1 = store, 0 = load; sampled with req.
REQ-007 size  input  2  00 byte, 01 halfword, 10 word; 11 SHALL be treated as word.
REQ-008 sign_ext  input  1  loads only: 1 sign-extend, 0 zero-extend.
REQ-009 addr  input  32  byte address; word index = addr[log2(DEPTH)+1:2], upper bits ignored.
REQ-010 wdata  input  32  store data, right-justified for byte/half.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 done  output  1  one-cycle completion pulse; drives the downstream load-data register enable.
REQ-013 rdata  output  32  extended load result, valid while done=1 and held until the next load completes.
REQ-014 misalign  output  1  valid with done; 1 = access rejected.

Function
REQ-015 FSM states: IDLE, RD, WR, RESP; encoding from the shared package.
REQ-016 IDLE + req: latch we/size/sign_ext/addr/wdata; misaligned (half with addr[0]=1, word with addr[1:0]!=0) -> RESP with misalign=1; else -> RD.
REQ-017 RD: read the addressed word into an internal register; load -> RESP, store -> WR.
REQ-018 WR: merge latched wdata into the read word at the byte lane(s) given by addr[1:0]/size, write the merged word; -> RESP.
REQ-019 RESP: done=1 for exactly one cycle; -> IDLE.
REQ-020 Latency from req-sampling edge: load done 2 cycles later, store done 3 cycles later, misaligned done 1 cycle later.
REQ-021 Load extraction: byte lane = addr[1:0], half lane = addr[1]; lane 0 = bits [7:0]/[15:0] (little-endian).
REQ-022 A misaligned access SHALL NOT modify the array or rdata.
REQ-023 misalign SHALL be 0 on every aligned completion and hold its value until the next done.
REQ-024 req while busy SHALL be ignored; no queueing.
REQ-025 Input changes after the sampling edge SHALL NOT affect the operation in flight.
REQ-026 A load from a word written by the immediately preceding store SHALL return the new data.
REQ-027 rdata SHALL be unchanged by store completions.

Reset
REQ-028 rst_n=0 at an edge: state=IDLE, busy=0, done=0, misalign=0, rdata=0, latched request cleared.
REQ-029 Reset during WR-cycle edge SHALL suppress that write; array contents otherwise retained.
REQ-030 req with rst_n=0 SHALL be ignored.

Structure
REQ-031 Shared package holds FSM state typedef, size encodings (SZ_BYTE, SZ_HALF, SZ_WORD) and word width constant.
REQ-032 One sub-module, dmem_lane_mux: combinational byte/half extract-and-extend plus store-merge; FSM and array in the top.

Verification
REQ-033 Store word 0xDEADBEEF to 0x10, load word 0x10 -> done at req+2, rdata=0xDEADBEEF, misalign=0.
REQ-034 After REQ-033, load byte 0x13 sign_ext=1 -> rdata=0xFFFFFFDE; sign_ext=0 -> 0x000000DE; load half 0x10 sign_ext=1 -> 0xFFFFBEEF.
REQ-035 Store byte 0x55 to 0x11 over 0xDEADBEEF -> done at req+3; load word 0x10 -> 0xDEAD55EF.
REQ-036 Load word at 0x12 -> done at req+1, misalign=1, rdata unchanged; store half at 0x21 -> misalign=1, word 0x20 unchanged.
REQ-037 req pulsed again during RD -> ignored, exactly one done; rst_n=0 in WR cycle of a store to 0x30 -> word 0x30 unchanged, all outputs 0.
